// File: rtl/fu_mem_pkg.sv
// fu_mem_pkg
// Shared definitions for the load/store functional unit:
//   - opcode encodings for load and store
//   - the four-state sequencing FSM
//   - width helper constants used by the unit and its address generator
package fu_mem_pkg;

    // Opcode width that the load/store encodings are defined in.
    localparam int OP_BITS = 3;

    localparam logic [OP_BITS-1:0] OP_LOAD  = 3'b110;
    localparam logic [OP_BITS-1:0] OP_STORE = 3'b111;

    // Default datapath geometry.
    localparam int DEF_SIZE     = 32;
    localparam int DEF_REG_NUM  = 8;
    localparam int DEF_MEM_ROWS = 64;

    // IDLE -> READ -> ACCESS -> DONE -> IDLE, one instruction in flight.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_READ   = 2'd1,
        ST_ACCESS = 2'd2,
        ST_DONE   = 2'd3
    } fu_state_e;

endpackage

// File: rtl/fu_mem_agu.sv
// fu_mem_agu
// Combinational address generator for the load/store unit.
//   op           : latched opcode (selects the offset source)
//   use_imm      : offset comes from imm instead of a register
//   imm          : immediate offset
//   rs1, rs2     : base operand and second register operand
//   addr         : effective address truncated to the memory index width
//   out_of_range : full-width effective address is beyond the memory size
// Loads use rs2 as a register offset; stores use rs2 as data, so their
// non-immediate offset is zero.
module fu_mem_agu
    import fu_mem_pkg::*;
#(
    parameter int SIZE       = DEF_SIZE,
    parameter int ALUOP_BITS = OP_BITS,
    parameter int MEM_ROWS   = DEF_MEM_ROWS,
    parameter int AW         = $clog2(MEM_ROWS)
) (
    input  logic [ALUOP_BITS-1:0] op,
    input  logic                  use_imm,
    input  logic [SIZE-1:0]       imm,
    input  logic [SIZE-1:0]       rs1,
    input  logic [SIZE-1:0]       rs2,
    output logic [AW-1:0]         addr,
    output logic                  out_of_range
);

    logic [SIZE-1:0] off;
    logic [SIZE-1:0] ea;

    always_comb begin
        off = '0;
        if (use_imm) begin
            off = imm;
        end else if (op == ALUOP_BITS'(OP_LOAD)) begin
            off = rs2;
        end
    end

    // Sum wraps modulo 2^SIZE by construction.
    assign ea           = rs1 + off;
    assign addr         = ea[AW-1:0];
    assign out_of_range = (ea >= SIZE'(MEM_ROWS));

endmodule

// File: rtl/fu_mem_unit.sv
// fu_mem_unit
// Load/store functional unit. Accepts one issued memory instruction at a
// time, reads base/data operands from the register file, performs one word
// access to data memory, writes load results back and pulses Comp on retire.
//
// Ports:
//   clk, reset        : clock (rising edge), asynchronous active-high reset
//   ALUOp, src_reg1, src_reg2, use_imm, imm, dest_reg1, issue : issue bus
//   read_reg          : register file read addresses ([0]=base, [1]=src2)
//   read_data_reg     : combinational register file read data
//   RegWrite, write_reg, write_data_reg : register file write port
//   EnWrite, write_addr, write_data_mem : data memory write port
//   read_addr, read_data_mem            : data memory read port
//   Comp              : one-cycle completion pulse
//
// Build option: define FU_MEM_BOUNDS_CHECK_EN to suppress accesses whose
// full effective address is >= MEM_ROWS (stores do not write, loads return
// zero). Without it, addresses wrap modulo MEM_ROWS.
module fu_mem_unit
    import fu_mem_pkg::*;
#(
    parameter int SIZE       = DEF_SIZE,
    parameter int REG_NUM    = DEF_REG_NUM,
    parameter int ALUOP_BITS = OP_BITS,
    parameter int MEM_ROWS   = DEF_MEM_ROWS,
    localparam int RW        = $clog2(REG_NUM),
    localparam int AW        = $clog2(MEM_ROWS)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [ALUOP_BITS-1:0]       ALUOp,
    input  logic [RW-1:0]               src_reg1,
    input  logic [RW-1:0]               src_reg2,
    input  logic                        use_imm,
    input  logic [SIZE-1:0]             imm,
    input  logic [RW-1:0]               dest_reg1,
    input  logic                        issue,
    output logic [1:0][RW-1:0]          read_reg,
    input  logic [1:0][SIZE-1:0]        read_data_reg,
    output logic                        RegWrite,
    output logic [0:0][RW-1:0]          write_reg,
    output logic [0:0][SIZE-1:0]        write_data_reg,
    output logic [0:0]                  EnWrite,
    output logic [0:0][AW-1:0]          write_addr,
    output logic [0:0][SIZE-1:0]        write_data_mem,
    output logic [0:0][AW-1:0]          read_addr,
    input  logic [0:0][SIZE-1:0]        read_data_mem,
    output logic                        Comp
);

    fu_state_e state_q, state_d;

    // Instruction fields latched at issue.
    logic [ALUOP_BITS-1:0] op_q, op_d;
    logic [RW-1:0]         src1_q, src1_d;
    logic [RW-1:0]         src2_q, src2_d;
    logic [RW-1:0]         dest_q, dest_d;
    logic                  use_imm_q, use_imm_d;
    logic [SIZE-1:0]       imm_q, imm_d;

    // Access suppression decided when operands are captured.
    logic                  oob_q, oob_d;

    // Registered address/data outputs; they hold between instructions.
    logic [AW-1:0]         write_addr_q, write_addr_d;
    logic [SIZE-1:0]       write_data_mem_q, write_data_mem_d;
    logic [AW-1:0]         read_addr_q, read_addr_d;
    logic [RW-1:0]         write_reg_q, write_reg_d;
    logic [SIZE-1:0]       write_data_reg_q, write_data_reg_d;

    logic                  is_load;
    logic                  is_store;
    logic [AW-1:0]         agu_addr;
    logic                  agu_oob;
    logic                  suppress;

    assign is_load  = (op_q == ALUOP_BITS'(OP_LOAD));
    assign is_store = (op_q == ALUOP_BITS'(OP_STORE));

    // The address generator works on the register file data arriving during
    // READ, so the effective address is ready to register at the READ edge.
    fu_mem_agu #(
        .SIZE       (SIZE),
        .ALUOP_BITS (ALUOP_BITS),
        .MEM_ROWS   (MEM_ROWS),
        .AW         (AW)
    ) u_agu (
        .op           (op_q),
        .use_imm      (use_imm_q),
        .imm          (imm_q),
        .rs1          (read_data_reg[0]),
        .rs2          (read_data_reg[1]),
        .addr         (agu_addr),
        .out_of_range (agu_oob)
    );

`ifdef FU_MEM_BOUNDS_CHECK_EN
    assign suppress = agu_oob;
`else
    // Wrap-around build: the range flag is intentionally ignored.
    logic unused_agu_oob;
    assign unused_agu_oob = agu_oob;
    assign suppress       = 1'b0;
`endif

    always_comb begin
        state_d          = state_q;
        op_d             = op_q;
        src1_d           = src1_q;
        src2_d           = src2_q;
        dest_d           = dest_q;
        use_imm_d        = use_imm_q;
        imm_d            = imm_q;
        oob_d            = oob_q;
        write_addr_d     = write_addr_q;
        write_data_mem_d = write_data_mem_q;
        read_addr_d      = read_addr_q;
        write_reg_d      = write_reg_q;
        write_data_reg_d = write_data_reg_q;

        case (state_q)
            ST_IDLE: begin
                // Only IDLE looks at issue, so a held issue cannot re-enter.
                if (issue) begin
                    op_d      = ALUOp;
                    src1_d    = src_reg1;
                    src2_d    = src_reg2;
                    dest_d    = dest_reg1;
                    use_imm_d = use_imm;
                    imm_d     = imm;
                    state_d   = ST_READ;
                end
            end
            ST_READ: begin
                oob_d = suppress;
                if (is_store && !suppress) begin
                    write_addr_d     = agu_addr;
                    write_data_mem_d = read_data_reg[1];
                end
                if (is_load && !suppress) begin
                    read_addr_d = agu_addr;
                end
                state_d = ST_ACCESS;
            end
            ST_ACCESS: begin
                // Load data is taken now; sources were captured already, so a
                // destination equal to a source is harmless.
                if (is_load) begin
                    write_reg_d      = dest_q;
                    write_data_reg_d = oob_q ? '0 : read_data_mem[0];
                end
                state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q          <= ST_IDLE;
            op_q             <= '0;
            src1_q           <= '0;
            src2_q           <= '0;
            dest_q           <= '0;
            use_imm_q        <= 1'b0;
            imm_q            <= '0;
            oob_q            <= 1'b0;
            write_addr_q     <= '0;
            write_data_mem_q <= '0;
            read_addr_q      <= '0;
            write_reg_q      <= '0;
            write_data_reg_q <= '0;
        end else begin
            state_q          <= state_d;
            op_q             <= op_d;
            src1_q           <= src1_d;
            src2_q           <= src2_d;
            dest_q           <= dest_d;
            use_imm_q        <= use_imm_d;
            imm_q            <= imm_d;
            oob_q            <= oob_d;
            write_addr_q     <= write_addr_d;
            write_data_mem_q <= write_data_mem_d;
            read_addr_q      <= read_addr_d;
            write_reg_q      <= write_reg_d;
            write_data_reg_q <= write_data_reg_d;
        end
    end

    // Strobes decode straight from the state register so an asynchronous
    // reset removes them immediately.
    assign read_reg[0]       = src1_q;
    assign read_reg[1]       = src2_q;
    assign EnWrite[0]        = (state_q == ST_ACCESS) && is_store && !oob_q;
    assign Comp              = (state_q == ST_DONE);
    assign RegWrite          = (state_q == ST_DONE) && is_load;
    assign write_reg[0]      = write_reg_q;
    assign write_data_reg[0] = write_data_reg_q;
    assign write_addr[0]     = write_addr_q;
    assign write_data_mem[0] = write_data_mem_q;
    assign read_addr[0]      = read_addr_q;

endmodule

// File: tb/tb_fu_mem_unit.sv
module tb_fu_mem_unit;

    localparam int SIZE = 32;
    localparam int RW   = 3;
    localparam int AW   = 6;

    logic                 clk;
    logic                 reset;
    logic [2:0]           ALUOp;
    logic [RW-1:0]        src_reg1;
    logic [RW-1:0]        src_reg2;
    logic                 use_imm;
    logic [SIZE-1:0]      imm;
    logic [RW-1:0]        dest_reg1;
    logic                 issue;
    logic [1:0][RW-1:0]   read_reg;
    logic [1:0][SIZE-1:0] read_data_reg;
    logic                 RegWrite;
    logic [0:0][RW-1:0]   write_reg;
    logic [0:0][SIZE-1:0] write_data_reg;
    logic [0:0]           EnWrite;
    logic [0:0][AW-1:0]   write_addr;
    logic [0:0][SIZE-1:0] write_data_mem;
    logic [0:0][AW-1:0]   read_addr;
    logic [0:0][SIZE-1:0] read_data_mem;
    logic                 Comp;

    fu_mem_unit dut (
        .clk            (clk),
        .reset          (reset),
        .ALUOp          (ALUOp),
        .src_reg1       (src_reg1),
        .src_reg2       (src_reg2),
        .use_imm        (use_imm),
        .imm            (imm),
        .dest_reg1      (dest_reg1),
        .issue          (issue),
        .read_reg       (read_reg),
        .read_data_reg  (read_data_reg),
        .RegWrite       (RegWrite),
        .write_reg      (write_reg),
        .write_data_reg (write_data_reg),
        .EnWrite        (EnWrite),
        .write_addr     (write_addr),
        .write_data_mem (write_data_mem),
        .read_addr      (read_addr),
        .read_data_mem  (read_data_mem),
        .Comp           (Comp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Environment: register file and data memory with combinational reads.
    logic [SIZE-1:0] rf  [8];
    logic [SIZE-1:0] mem [64];
    logic            bk_rf_we, bk_mem_we;
    logic [5:0]      bk_addr;
    logic [SIZE-1:0] bk_data;

    always_comb begin
        read_data_reg[0] = rf[read_reg[0]];
        read_data_reg[1] = rf[read_reg[1]];
        read_data_mem[0] = mem[read_addr[0]];
    end

    always @(posedge clk) begin
        if (RegWrite) rf[write_reg[0]] <= write_data_reg[0];
        if (EnWrite[0]) mem[write_addr[0]] <= write_data_mem[0];
        if (bk_rf_we) rf[bk_addr[2:0]] <= bk_data;
        if (bk_mem_we) mem[bk_addr] <= bk_data;
    end

    typedef struct {
        logic [2:0]      dest;
        logic [SIZE-1:0] data;
        logic [AW-1:0]   addr;
        logic            mem_en;
        logic            reg_en;
    } exp_t;

    exp_t sb[$];
    int   tests_run = 0;
    int   tests_failed = 0;

    task automatic poke(input logic is_mem, input logic [5:0] a, input logic [SIZE-1:0] d);
        @(negedge clk);
        bk_rf_we  = ~is_mem;
        bk_mem_we = is_mem;
        bk_addr   = a;
        bk_data   = d;
        @(negedge clk);
        bk_rf_we  = 1'b0;
        bk_mem_we = 1'b0;
    endtask

    // Issue one instruction, push the model's expectation, then watch six
    // cycles checking strobes against the scoreboard head.
    task automatic run_op(input logic [2:0] op, input logic [2:0] s1, input logic [2:0] s2,
                          input logic ui, input logic [SIZE-1:0] im, input logic [2:0] dst,
                          input int hold, input string name);
        exp_t            e;
        logic [SIZE-1:0] off, ea;
        logic            oob;
        int              comp_cnt, comp_cyc, enw_cnt, regw_cnt;
        comp_cnt = 0; comp_cyc = 0; enw_cnt = 0; regw_cnt = 0;
        off = ui ? im : ((op == 3'b110) ? rf[s2] : '0);
        ea  = rf[s1] + off;
        oob = 1'b0;
`ifdef FU_MEM_BOUNDS_CHECK_EN
        oob = (ea >= 32'd64);
`endif
        e.dest   = dst;
        e.addr   = ea[AW-1:0];
        e.mem_en = (op == 3'b111) && !oob;
        e.reg_en = (op == 3'b110);
        e.data   = (op == 3'b111) ? rf[s2] : (oob ? '0 : mem[ea[AW-1:0]]);
        sb.push_back(e);

        @(negedge clk);
        ALUOp = op; src_reg1 = s1; src_reg2 = s2; use_imm = ui; imm = im;
        dest_reg1 = dst; issue = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            @(posedge clk);
            #1;
            if (c >= hold) issue = 1'b0;
            if (EnWrite[0]) begin
                enw_cnt++;
                tests_run++;
                if (write_addr[0] !== sb[0].addr || write_data_mem[0] !== sb[0].data) begin
                    tests_failed++;
                    $display("FAIL %s_memwrite: got addr=%0d data=%0h, need addr=%0d data=%0h",
                             name, write_addr[0], write_data_mem[0], sb[0].addr, sb[0].data);
                end
            end
            if (Comp) begin
                comp_cnt++;
                comp_cyc = c;
            end
            if (RegWrite) begin
                regw_cnt++;
                tests_run++;
                if (write_reg[0] !== sb[0].dest || write_data_reg[0] !== sb[0].data || !Comp) begin
                    tests_failed++;
                    $display("FAIL %s_regwrite: got reg=%0d data=%0h comp=%0b, need reg=%0d data=%0h comp=1",
                             name, write_reg[0], write_data_reg[0], Comp, sb[0].dest, sb[0].data);
                end
            end
        end
        e = sb.pop_front();
        tests_run++;
        if (comp_cnt != 1 || comp_cyc != 3) begin
            tests_failed++;
            $display("FAIL %s_comp: got %0d pulses at cycle %0d, need 1 pulse at cycle 3",
                     name, comp_cnt, comp_cyc);
        end
        tests_run++;
        if (enw_cnt != int'(e.mem_en) || regw_cnt != int'(e.reg_en)) begin
            tests_failed++;
            $display("FAIL %s_strobes: got EnWrite=%0d RegWrite=%0d cycles, need %0d/%0d",
                     name, enw_cnt, regw_cnt, e.mem_en, e.reg_en);
        end
    endtask

    task automatic check_word(input string name, input logic [SIZE-1:0] got, input logic [SIZE-1:0] need);
        tests_run++;
        if (got !== need) begin
            tests_failed++;
            $display("FAIL %s: got %0h, need %0h", name, got, need);
        end
    endtask

    function automatic logic [127:0] all_outputs();
        return 128'({RegWrite, EnWrite, Comp, read_reg, write_reg, write_data_reg,
                     write_addr, write_data_mem, read_addr});
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        #1;
        tests_run++;
        if (all_outputs() !== '0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got %0h, need 0", all_outputs());
        end
        for (int i = 0; i < 8; i++) rf[i] = '0;
        for (int i = 0; i < 64; i++) mem[i] = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        $display("[TB] reset checked");
    endtask

    task automatic test_store();
        poke(1'b0, 6'd2, 32'd111);
        poke(1'b0, 6'd0, 32'd0);
        run_op(3'b111, 3'd0, 3'd2, 1'b1, 32'd0, 3'd0, 2, "store");
        check_word("store_mem0", mem[0], 32'd111);
        $display("[TB] store r2 -> mem[0] done");
    endtask

    task automatic test_load();
        poke(1'b1, 6'd5, 32'hDEAD);
        poke(1'b0, 6'd1, 32'd3);
        run_op(3'b110, 3'd1, 3'd0, 1'b1, 32'd2, 3'd4, 1, "load");
        @(negedge clk);
        check_word("load_r4", rf[4], 32'hDEAD);
        $display("[TB] load mem[5] -> r4 done");
    endtask

    task automatic test_reg_offset();
        poke(1'b0, 6'd1, 32'd10);
        poke(1'b0, 6'd3, 32'd6);
        poke(1'b1, 6'd16, 32'd42);
        run_op(3'b110, 3'd1, 3'd3, 1'b0, 32'd0, 3'd5, 1, "regoff");
        @(negedge clk);
        check_word("regoff_r5", rf[5], 32'd42);
        $display("[TB] register-offset load -> r5 done");
    endtask

    task automatic test_wrap();
        logic [SIZE-1:0] need_mem3, need_r6;
        poke(1'b0, 6'd1, 32'd60);
        poke(1'b0, 6'd2, 32'd111);
        poke(1'b1, 6'd3, 32'h33);
`ifdef FU_MEM_BOUNDS_CHECK_EN
        need_mem3 = 32'h33;
        need_r6   = 32'd0;
`else
        need_mem3 = 32'd111;
        need_r6   = 32'd111;
`endif
        run_op(3'b111, 3'd1, 3'd2, 1'b1, 32'd7, 3'd0, 1, "wrap_store");
        check_word("wrap_mem3", mem[3], need_mem3);
        run_op(3'b110, 3'd1, 3'd0, 1'b1, 32'd7, 3'd6, 1, "wrap_load");
        @(negedge clk);
        check_word("wrap_r6", rf[6], need_r6);
        $display("[TB] wrap store/load at ea=67 done");
    endtask

    task automatic test_reset_mid_op();
        int comp_seen;
        comp_seen = 0;
        poke(1'b1, 6'd9, 32'h55);
        poke(1'b0, 6'd2, 32'hABCD);
        @(negedge clk);
        ALUOp = 3'b111; src_reg1 = 3'd0; src_reg2 = 3'd2; use_imm = 1'b1; imm = 32'd9;
        dest_reg1 = 3'd0; issue = 1'b1;
        @(posedge clk);
        #1 issue = 1'b0;
        @(posedge clk);
        #1;
        tests_run++;
        if (EnWrite[0] !== 1'b1) begin
            tests_failed++;
            $display("FAIL midreset_access: got EnWrite=%0b, need 1", EnWrite[0]);
        end
        reset = 1'b1;
        #1;
        tests_run++;
        if (all_outputs() !== '0) begin
            tests_failed++;
            $display("FAIL midreset_outputs: got %0h, need 0", all_outputs());
        end
        @(negedge clk);
        reset = 1'b0;
        repeat (4) begin
            @(posedge clk);
            #1;
            if (Comp) comp_seen++;
        end
        tests_run++;
        if (comp_seen != 0) begin
            tests_failed++;
            $display("FAIL midreset_comp: got %0d pulses, need 0", comp_seen);
        end
        check_word("midreset_mem9", mem[9], 32'h55);
        $display("[TB] reset during store ACCESS done");
    endtask

    task automatic test_noop();
        run_op(3'b000, 3'd1, 3'd2, 1'b0, 32'd0, 3'd3, 1, "noop");
        $display("[TB] no-op opcode done");
    endtask

    task automatic test_back_to_back();
        poke(1'b0, 6'd7, 32'd2);
        poke(1'b1, 6'd7, 32'h77);
        // Destination equals base register; issue held into DONE is dropped.
        run_op(3'b110, 3'd7, 3'd0, 1'b1, 32'd5, 3'd7, 4, "b2b_load_self");
        run_op(3'b111, 3'd7, 3'd4, 1'b1, 32'd1, 3'd0, 1, "b2b_store");
        check_word("b2b_r7", rf[7], 32'h77);
        check_word("b2b_mem120", mem[8'h78 & 8'h3F], 32'hDEAD);
        $display("[TB] back-to-back done");
    endtask

    initial begin
        issue = 1'b0; ALUOp = '0; src_reg1 = '0; src_reg2 = '0; use_imm = 1'b0;
        imm = '0; dest_reg1 = '0; bk_rf_we = 1'b0; bk_mem_we = 1'b0;
        bk_addr = '0; bk_data = '0;
        test_reset();
        test_store();
        test_load();
        test_reg_offset();
        test_wrap();
        test_reset_mid_op();
        test_noop();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
